// File: rtl/bomb_engine.sv
// Bomb map engine: per-cell fuse counters, chained blasts, player damage and game result.
// Define BOMB_WALLS_EN to add a wall_map input that stops blast arms and blocks placement.
module bomb_engine #(
    parameter int GRID_W     = 10,
    parameter int GRID_H     = 10,
    parameter int FUSE       = 3,
    parameter int RADIUS     = 2,
    parameter int NPLAYERS   = 2,
    parameter int HEALTH_W   = 2,
    parameter int MAX_HEALTH = 3
) (
    input  logic                         bombClk,
    input  logic                         rst,
`ifdef BOMB_WALLS_EN
    input  logic [GRID_W*GRID_H-1:0]     wall_map,
`endif
    input  logic [4*NPLAYERS-1:0]        player_x,
    input  logic [4*NPLAYERS-1:0]        player_y,
    input  logic [NPLAYERS-1:0]          place_v,
    input  logic [4*NPLAYERS-1:0]        place_x,
    input  logic [4*NPLAYERS-1:0]        place_y,
    output logic [NPLAYERS-1:0]          place_ack,
    output logic [GRID_W*GRID_H-1:0]     bomb_map,
    output logic [GRID_W*GRID_H-1:0]     blast_map,
    output logic [HEALTH_W*NPLAYERS-1:0] health,
    output logic [1:0]                   game_state,
    output logic [1:0]                   winner
);
    localparam int NCELL = GRID_W * GRID_H;
    localparam int FW    = $clog2(FUSE + 1);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_WIN = 2'd1, ST_DRAW = 2'd2} state_t;

`ifndef BOMB_WALLS_EN
    logic [NCELL-1:0] wall_map;
    assign wall_map = '0;
`endif

    logic [FW-1:0]       fuse_q [NCELL];
    logic [FW-1:0]       fuse_d [NCELL];
    logic [HEALTH_W-1:0] hp_q   [NPLAYERS];
    logic [HEALTH_W-1:0] hp_d   [NPLAYERS];
    logic [NCELL-1:0]    det, blast_d, blast_q, place_hit;
    logic [NPLAYERS-1:0] ack_d, ack_q;
    state_t              state_d, state_q;
    logic [1:0]          winner_d, winner_q;

    // Each arm walks outward and closes at the grid edge or just before a wall.
    function automatic logic [NCELL-1:0] blast_of(input logic [NCELL-1:0] src,
                                                  input logic [NCELL-1:0] walls);
        logic [NCELL-1:0] b;
        logic             open;
        int               nx, ny;
        b = '0;
        for (int x = 0; x < GRID_W; x++) begin
            for (int y = 0; y < GRID_H; y++) begin
                if (src[x*GRID_H+y]) begin
                    b[x*GRID_H+y] = 1'b1;
                    for (int dir = 0; dir < 4; dir++) begin
                        open = 1'b1;
                        for (int k = 1; k <= RADIUS; k++) begin
                            nx = x + ((dir == 0) ? k : (dir == 1) ? -k : 0);
                            ny = y + ((dir == 2) ? k : (dir == 3) ? -k : 0);
                            if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) open = 1'b0;
                            else if (walls[nx*GRID_H+ny]) open = 1'b0;
                            else if (open) b[nx*GRID_H+ny] = 1'b1;
                        end
                    end
                end
            end
        end
        return b;
    endfunction

    // Only live bombs detonate; a blast over an empty cell does not propagate.
    always_comb begin
        for (int c = 0; c < NCELL; c++)
            det[c] = (fuse_q[c] == FW'(1)) || ((fuse_q[c] != '0) && blast_q[c]);
    end

    assign blast_d = blast_of(det, wall_map);

    always_comb begin
        int px, py;
        ack_d     = '0;
        place_hit = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            px = int'(place_x[4*p +: 4]);
            py = int'(place_y[4*p +: 4]);
            if (place_v[p] && state_q == ST_RUN && hp_q[p] != '0 && px < GRID_W && py < GRID_H) begin
                if (fuse_q[px*GRID_H+py] == '0 && !blast_d[px*GRID_H+py] &&
                    !wall_map[px*GRID_H+py] && !place_hit[px*GRID_H+py]) begin
                    ack_d[p]                 = 1'b1;
                    place_hit[px*GRID_H+py]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCELL; c++) begin
            if (det[c])                fuse_d[c] = '0;
            else if (fuse_q[c] > FW'(1)) fuse_d[c] = fuse_q[c] - FW'(1);
            else if (place_hit[c])     fuse_d[c] = FW'(FUSE);
            else                       fuse_d[c] = fuse_q[c];
        end
    end

    // Health is frozen once the game has a result.
    always_comb begin
        int px, py;
        for (int p = 0; p < NPLAYERS; p++) begin
            px      = int'(player_x[4*p +: 4]);
            py      = int'(player_y[4*p +: 4]);
            hp_d[p] = hp_q[p];
            if (state_q == ST_RUN && hp_q[p] != '0 && px < GRID_W && py < GRID_H) begin
                if (blast_d[px*GRID_H+py]) hp_d[p] = hp_q[p] - HEALTH_W'(1);
            end
        end
    end

    always_comb begin
        int         n_alive;
        logic [1:0] last_alive;
        n_alive    = 0;
        last_alive = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            if (hp_q[p] != '0) begin
                n_alive    = n_alive + 1;
                last_alive = 2'(p);
            end
        end
        state_d  = state_q;
        winner_d = winner_q;
        if (state_q == ST_RUN) begin
            if (n_alive == 1) begin
                state_d  = ST_WIN;
                winner_d = last_alive;
            end else if (n_alive == 0) begin
                state_d  = ST_DRAW;
            end
        end
    end

    always_ff @(posedge bombClk) begin
        if (rst) begin
            for (int c = 0; c < NCELL; c++) fuse_q[c] <= '0;
            for (int p = 0; p < NPLAYERS; p++) hp_q[p] <= HEALTH_W'(MAX_HEALTH);
            blast_q  <= '0;
            ack_q    <= '0;
            state_q  <= ST_RUN;
            winner_q <= '0;
        end else begin
            fuse_q   <= fuse_d;
            hp_q     <= hp_d;
            blast_q  <= blast_d;
            ack_q    <= ack_d;
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NCELL; c++) bomb_map[c] = (fuse_q[c] != '0);
        for (int p = 0; p < NPLAYERS; p++) health[HEALTH_W*p +: HEALTH_W] = hp_q[p];
    end

    assign blast_map  = blast_q;
    assign place_ack  = ack_q;
    assign game_state = state_q;
    assign winner     = winner_q;

endmodule
